stack_sequencer: RTL and testbench

Sequences the multi-byte memory transfers of the 6809 stack instructions PSHS/PSHU/PULS/PULU for the control unit. The control unit hands over the postbyte register mask, the direction and the starting stack pointer, then waits for `done`. The block walks the selected registers in 6809 order, drives one memory access per byte through a req/ack handshake, and tells the datapath which register byte to source or sink. At the end it returns the updated stack pointer for write-back.

---
 rtl/stack_sequencer_if.sv | 20 ++
 rtl/stack_sequencer.sv | 101 ++++++++++
 tb/tb_stack_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - memory access bus between the stack sequencer and memory
interface stack_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        byte_sel;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, byte_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, byte_sel,
    output mem_ack
  );
endinterface

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - sequences 6809 PSHS/PSHU/PULS/PULU byte transfers
module stack_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pull,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] sp_in,
  stack_sequencer_if.master bus,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              pull_q;
  logic [11:0]       pending;
  logic [ADDR_W-1:0] sp;
  logic [3:0]        cur;
  logic [11:0]       pending_after;
  logic              last;
  logic              xfer;

  // One pending bit per register byte, indexed by byte_sel code.
  function automatic logic [11:0] expand(input logic [7:0] m);
    expand = {m[7], m[7], m[6], m[6], m[5], m[5], m[4], m[4], m[3:0]};
  endfunction

  // Push visits the highest pending byte first, pull the lowest.
  always_comb begin
    cur = 4'd0;
    if (pull_q) begin
      for (int i = 11; i >= 0; i--) begin
        if (pending[i]) cur = 4'(i);
      end
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (pending[i]) cur = 4'(i);
      end
    end
  end

  assign pending_after = pending & ~(12'd1 << cur);
  assign last          = (pending_after == 12'd0);
  assign xfer          = (state == XFER);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (mask == 8'd0) ? DONE : XFER;
      XFER:    if (bus.mem_ack && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pull_q  <= 1'b0;
      pending <= 12'd0;
      sp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pull_q  <= pull;
            pending <= expand(mask);
            sp      <= sp_in;
          end
        end
        XFER: begin
          if (bus.mem_ack) begin
            pending <= pending_after;
            sp      <= pull_q ? sp + ADDR_W'(1) : sp - ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req  = xfer;
  assign bus.mem_we   = xfer && !pull_q;
  assign bus.mem_addr = xfer ? (pull_q ? sp : sp - ADDR_W'(1)) : '0;
  assign bus.byte_sel = xfer ? cur : 4'd0;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign sp_we  = (state == DONE);
  assign sp_out = sp;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - scoreboard bench for stack_sequencer with a byte-list reference model
module tb_stack_sequencer;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  sel;
  } access_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pull = 1'b0;
  logic [7:0]  mask = 8'd0;
  logic [15:0] sp_in = 16'd0;
  logic [15:0] sp_out;
  logic        sp_we;
  logic        busy;
  logic        done;

  int          total_cnt = 0;
  int          pass_cnt = 0;
  int          ack_wait = 0;
  int          ack_cnt = 0;
  access_t     exp_q[$];
  logic [15:0] exp_sp_q[$];

  stack_sequencer_if #(.ADDR_W(16)) bus ();

  stack_sequencer #(.ADDR_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .pull   (pull),
    .mask   (mask),
    .sp_in  (sp_in),
    .bus    (bus),
    .sp_out (sp_out),
    .sp_we  (sp_we),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Memory model: ack after ack_wait stall cycles; random ack noise while idle.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_cnt = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (ack_cnt >= ack_wait) begin
          bus.mem_ack = 1'b1;
          ack_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every request cycle must match the head of the expected access list.
  initial begin
    access_t a;
    logic [15:0] s;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (bus.mem_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            a = exp_q[0];
            chk("mem_we", 32'(bus.mem_we), 32'(a.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(a.addr));
            chk("byte_sel", 32'(bus.byte_sel), 32'(a.sel));
            if (bus.mem_ack) void'(exp_q.pop_front());
          end
        end
        if (done) begin
          if (exp_sp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            s = exp_sp_q.pop_front();
            chk("sp_out_at_done", 32'(sp_out), 32'(s));
            chk("sp_we_at_done", 32'(sp_we), 32'd1);
            chk("accesses_left_at_done", 32'(exp_q.size()), 32'd0);
          end
        end
      end
    end
  end

  // Reference: expand the postbyte into the 6809 byte list and walk the stack.
  task automatic model(input logic p, input logic [7:0] m, input logic [15:0] sp, output int n);
    int          bytes[$];
    logic [15:0] s;
    access_t     a;
    n = 0;
    s = sp;
    if (p) begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) begin
          if (b < 4) bytes.push_back(b);
          else begin
            bytes.push_back(2 * b - 4);
            bytes.push_back(2 * b - 3);
          end
        end
      end
    end else begin
      for (int b = 7; b >= 0; b--) begin
        if (m[b]) begin
          if (b < 4) bytes.push_back(b);
          else begin
            bytes.push_back(2 * b - 3);
            bytes.push_back(2 * b - 4);
          end
        end
      end
    end
    foreach (bytes[i]) begin
      if (p) begin
        a.we = 1'b0; a.addr = s; a.sel = 4'(bytes[i]);
        s = s + 16'd1;
      end else begin
        s = s - 16'd1;
        a.we = 1'b1; a.addr = s; a.sel = 4'(bytes[i]);
      end
      exp_q.push_back(a);
      n++;
    end
    exp_sp_q.push_back(s);
  endtask

  task automatic run_op(input logic p, input logic [7:0] m, input logic [15:0] sp, input int w, input bit poke);
    int n;
    int cyc;
    ack_wait = w;
    @(negedge clk);
    model(p, m, sp, n);
    start = 1'b1; pull = p; mask = m; sp_in = sp;
    @(negedge clk);
    start = 1'b0; pull = 1'($urandom); mask = 8'($urandom); sp_in = 16'($urandom);
    cyc = 1;
    forever begin
      #1;
      if (done) break;
      if (cyc > 400) begin
        chk("done_timeout", 32'd1, 32'd0);
        break;
      end
      if (poke && cyc == 2) begin
        start = 1'b1; pull = ~p; mask = ~m;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("done_cycle", 32'(cyc), 32'(n * (1 + w) + 1));
    @(negedge clk);
    #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("queue_drained", 32'(exp_q.size() + exp_sp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_byte_sel", 32'(bus.byte_sel), 32'd0);
    chk("rst_sp_out", 32'(sp_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sp_we", 32'(sp_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 8'hFF, 16'h8000, 0, 1'b0);
    run_op(1'b1, 8'h06, 16'h7FF4, 0, 1'b0);
    run_op(1'b0, 8'h00, 16'h1234, 0, 1'b0);
    run_op(1'b0, 8'h80, 16'h1000, 3, 1'b0);
    run_op(1'b0, 8'h01, 16'h0000, 0, 1'b0);
    run_op(1'b1, 8'h80, 16'hFFFF, 1, 1'b0);
    run_op(1'b0, 8'h3C, 16'h4000, 0, 1'b1);

    // Abort a full push at its third byte.
    ack_wait = 0;
    @(negedge clk);
    model(1'b0, 8'hFF, 16'h2000, n);
    start = 1'b1; pull = 1'b0; mask = 8'hFF; sp_in = 16'h2000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_sp_q.delete();
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sp_out", 32'(sp_out), 32'd0);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_op(1'b1, 8'hFF, 16'h7FF4, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
